// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel/window widths, default frame size,
// window-generator state encoding and the window byte-index helper.
package img_pkg;

    localparam int PIX_W      = 8;
    localparam int WIN_N      = 9;
    localparam int WIN_W      = PIX_W * WIN_N;
    localparam int POS_W      = 9;
    localparam int DEF_WIDTH  = 410;
    localparam int DEF_HEIGHT = 361;

    typedef enum logic [1:0] {
        ACTIVE,
        COL_PAD,
        ROW_FLUSH
    } win_state_e;

    // Byte k of a packed window; dr/dc are row/column offsets mapped -1..+1 -> 0..2.
    function automatic int unsigned win_idx(input int unsigned dr, input int unsigned dc);
        return 3 * dr + dc;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line memory: synchronous write, combinational read, so a read
// and write to the same address in one cycle returns the old contents.
module line_buffer #(
    parameter int DEPTH = 410,
    parameter int DW    = 16,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/window_gen3x3.sv
// Streaming 3x3 zero-padded window generator: two line buffers plus a column
// shift register, walking a (WIDTH+1)x(HEIGHT+1) virtual grid to flush edges.
module window_gen3x3
    import img_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               HEIGHT    = DEF_HEIGHT,
    parameter logic [PIX_W-1:0] PAD_VALUE = 8'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIN_W-1:0] window,
    output logic             win_valid,
    output logic [POS_W-1:0] win_row,
    output logic [POS_W-1:0] win_col,
    output logic             frame_done
);

    localparam int LB_AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [POS_W-1:0] X_LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] X_PAD  = POS_W'(WIDTH);
    localparam logic [POS_W-1:0] Y_LAST = POS_W'(HEIGHT - 1);
    localparam logic [POS_W-1:0] Y_PAD  = POS_W'(HEIGHT);
    localparam logic [POS_W-1:0] ONE    = POS_W'(1);

    win_state_e state, state_nxt;

    logic [POS_W-1:0] vx, vy;
    logic             advance;
    logic             real_adv;
    logic             emit;

    logic [LB_AW-1:0]   lb_addr;
    logic [2*PIX_W-1:0] lb_rd;
    logic [2*PIX_W-1:0] lb_wr;

    // Columns indexed by dr: [0]=top (row vy-2), [1]=mid (row vy-1), [2]=bottom (row vy).
    logic [2:0][PIX_W-1:0] col_l, col_c, col_n;
    logic [2:0][PIX_W-1:0] ml, mc, mr;
    logic [WIN_W-1:0]      win_nxt;

    assign in_ready = (state == ACTIVE);
    assign advance  = (state != ACTIVE) || in_valid;
    assign real_adv = (state == ACTIVE) && in_valid;
    assign emit     = advance && (vx != '0) && (vy != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ACTIVE: begin
                if (in_valid && vx == X_LAST) begin
                    state_nxt = (vy == Y_LAST) ? ROW_FLUSH : COL_PAD;
                end
            end
            COL_PAD: begin
                state_nxt = ACTIVE;
            end
            ROW_FLUSH: begin
                if (vx == X_PAD && vy == Y_PAD) begin
                    state_nxt = ACTIVE;
                end
            end
            default: begin
                state_nxt = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACTIVE;
            vx    <= '0;
            vy    <= '0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                if (vx == X_PAD) begin
                    vx <= '0;
                    vy <= (vy == Y_PAD) ? '0 : vy + ONE;
                end else begin
                    vx <= vx + ONE;
                end
            end
        end
    end

    assign lb_addr = (vx < X_PAD) ? vx[LB_AW-1:0] : '0;
    assign lb_wr   = {lb_rd[PIX_W-1:0], pix_in};

    line_buffer #(
        .DEPTH (WIDTH),
        .DW    (2 * PIX_W),
        .AW    (LB_AW)
    ) u_lines (
        .clk     (clk),
        .we      (real_adv),
        .addr    (lb_addr),
        .wr_data (lb_wr),
        .rd_data (lb_rd)
    );

    assign col_n = {(vy == Y_PAD) ? PAD_VALUE : pix_in, lb_rd[PIX_W-1:0], lb_rd[2*PIX_W-1:PIX_W]};

    // The window is taken from the two held columns plus the live incoming one,
    // so it is centred at (vy-1, vx-1); masks follow directly from the counters.
    always_comb begin
        ml = col_l;
        mc = col_c;
        mr = col_n;
        if (vx == ONE) begin
            ml = {3{PAD_VALUE}};
        end
        if (vx == X_PAD) begin
            mr = {3{PAD_VALUE}};
        end
        if (vy == ONE) begin
            ml[0] = PAD_VALUE;
            mc[0] = PAD_VALUE;
            mr[0] = PAD_VALUE;
        end
        if (vy == Y_PAD) begin
            ml[2] = PAD_VALUE;
            mc[2] = PAD_VALUE;
            mr[2] = PAD_VALUE;
        end
        win_nxt = {mr[2], mc[2], ml[2], mr[1], mc[1], ml[1], mr[0], mc[0], ml[0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_l      <= '0;
            col_c      <= '0;
            window     <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (advance) begin
                col_l <= col_c;
                col_c <= col_n;
            end
            win_valid  <= emit;
            frame_done <= emit && (vx == X_PAD) && (vy == Y_PAD);
            if (emit) begin
                window  <= win_nxt;
                win_row <= vy - ONE;
                win_col <= vx - ONE;
            end
        end
    end

endmodule

// File: tb/tb_window_gen3x3.sv
// Randomised self-checking bench for window_gen3x3 on a 4x3 frame, comparing
// every emitted window against windows computed directly from the frame image.
module tb_window_gen3x3;
    import img_pkg::*;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  pix_in = 8'd0;

    logic        in_ready, win_valid, frame_done;
    logic [71:0] window;
    logic [8:0]  win_row, win_col;

    logic        in_ready_p, win_valid_p, frame_done_p;
    logic [71:0] window_p;
    logic [8:0]  win_row_p, win_col_p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc6_cyc = 0;
    int first_cyc = 0;

    logic [7:0] img [H][W];
    int         gaps [NPIX + 1];

    window_gen3x3 #(.WIDTH(W), .HEIGHT(H), .PAD_VALUE(8'd0)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .in_valid(in_valid), .in_ready(in_ready),
        .window(window), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done)
    );

    window_gen3x3 #(.WIDTH(W), .HEIGHT(H), .PAD_VALUE(8'd128)) dut_p (
        .clk(clk), .rst(rst), .pix_in(pix_in), .in_valid(in_valid), .in_ready(in_ready_p),
        .window(window_p), .win_valid(win_valid_p), .win_row(win_row_p), .win_col(win_col_p),
        .frame_done(frame_done_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c, input logic [7:0] pad);
        logic [71:0] w = '0;
        int y, x;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                y = r + dr - 1;
                x = c + dc - 1;
                w[8 * win_idx(unsigned'(dr), unsigned'(dc)) +: 8] =
                    (y < 0 || y >= H || x < 0 || x >= W) ? pad : img[y][x];
            end
        end
        return w;
    endfunction

    task automatic fill_ramp(input int base);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 8'(base + W * y + x + 1);
    endtask

    task automatic fill_rand();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 8'($urandom);
    endtask

    // Presents the frame in raster order; junk is driven whenever the pixel
    // cannot be accepted, so any spurious consumption corrupts the windows.
    task automatic drive_frame(input bit bubbles, input bit record_lat);
        int n = 0;
        int guard = 0;
        for (int i = 0; i <= NPIX; i++) gaps[i] = 0;
        while (n < NPIX && guard < 1000) begin
            guard++;
            if (bubbles && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                pix_in   = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                pix_in   = in_ready ? img[n / W][n % W] : 8'($urandom);
            end
            if (!in_ready) begin
                gaps[n]++;
            end else if (in_valid) begin
                if (record_lat && n == 5) acc6_cyc = cyc;
                n++;
            end
            @(negedge clk);
        end
        while (!in_ready && guard < 1000) begin
            guard++;
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_in   = 8'($urandom);
            gaps[n]++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("drv_pixels", n, NPIX);
    endtask

    task automatic check_frame(input bit literal);
        int k = 0;
        int t = 0;
        int r, c;
        while (k < NPIX && t < 400) begin
            @(negedge clk);
            t++;
            if (win_valid) begin
                r = k / W;
                c = k % W;
                if (k == 0) first_cyc = cyc;
                chk("row", win_row, r);
                chk("col", win_col, c);
                chk("win", window, exp_win(r, c, 8'd0));
                chk("done", frame_done, k == NPIX - 1);
                chk("p_valid", win_valid_p, 1'b1);
                chk("p_row", win_row_p, r);
                chk("p_col", win_col_p, c);
                chk("p_win", window_p, exp_win(r, c, 8'd128));
                chk("p_done", frame_done_p, k == NPIX - 1);
                if (literal) begin
                    // byte order k8..k0
                    if (k == 0) begin
                        chk("lit_w00", window, {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0});
                        chk("lit_w00_pad128", window_p,
                            {8'd6, 8'd5, 8'd128, 8'd2, 8'd1, 8'd128, 8'd128, 8'd128, 8'd128});
                    end
                    if (k == 5)
                        chk("lit_w11", window, {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});
                    if (k == NPIX - 1) begin
                        chk("lit_wlast", window, {8'd0, 8'd0, 8'd0, 8'd0, 8'd12, 8'd11, 8'd0, 8'd8, 8'd7});
                        chk("lit_done", frame_done, 1'b1);
                    end
                end
                k++;
            end else begin
                chk("done_idle", frame_done, 1'b0);
            end
        end
        chk("win_count", k, NPIX);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, in_ready, 1'b1);
        chk({tag, "_valid"}, win_valid, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_win"}, window, '0);
        chk({tag, "_row"}, win_row, '0);
        chk({tag, "_col"}, win_col, '0);
        chk({tag, "_pwin"}, window_p, '0);
        chk({tag, "_pready"}, in_ready_p, 1'b1);
    endtask

    initial begin
        int n;
        int guard;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", win_valid, 1'b0);
            chk("idle_ready", in_ready, 1'b1);
        end

        // Continuous ramp frame, followed back-to-back by a random frame.
        fill_ramp(0);
        fork
            drive_frame(1'b0, 1'b1);
            check_frame(1'b1);
        join
        chk("first_latency", first_cyc, acc6_cyc + 1);
        chk("gap_row0", gaps[4], 1);
        chk("gap_row1", gaps[8], 1);
        // row-end pad plus the W+1 pads of the virtual bottom row
        chk("gap_flush", gaps[NPIX], W + 2);

        fill_rand();
        fork
            drive_frame(1'b0, 1'b0);
            check_frame(1'b0);
        join

        fill_ramp(0);
        fork
            drive_frame(1'b1, 1'b0);
            check_frame(1'b1);
        join

        for (int f = 0; f < 3; f++) begin
            fill_rand();
            fork
                drive_frame(1'b1, 1'b0);
                check_frame(1'b0);
            join
        end

        // Abort a frame after 7 pixels with an asynchronous reset.
        fill_ramp(0);
        n = 0;
        guard = 0;
        while (n < 7 && guard < 100) begin
            guard++;
            in_valid = 1'b1;
            pix_in   = in_ready ? img[n / W][n % W] : 8'($urandom);
            if (in_ready) n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", win_valid, 1'b1);
        chk("pre_rst_win", window, exp_win(0, 1, 8'd0));
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;

        fill_ramp(100);
        fork
            drive_frame(1'b0, 1'b0);
            check_frame(1'b0);
        join

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
